// File: rtl/wb_cmd_pkg.sv
// Shared types for the Wishbone command initiator: FSM states, response
// status codes and the watchdog counter width helper.
package wb_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_ERR     = 2'd1,
    RSP_TIMEOUT = 2'd2
  } rsp_status_e;

  // Counter must reach TIMEOUT_CYCLES-1; kept within 8..16 bits.
  function automatic int wd_cnt_width(input int timeout_cycles);
    int w;
    w = $clog2(timeout_cycles + 1);
    if (w < 8) w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/wb_cmd_initiator_if.sv
// Command/response handshake plus the WBs_* Wishbone classic signal set.
interface wb_cmd_initiator_if #(
  parameter int ADR_W = 17,
  parameter int DAT_W = 32
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_we;
  logic [ADR_W-1:0]   cmd_adr;
  logic [DAT_W-1:0]   cmd_dat;
  logic [DAT_W/8-1:0] cmd_sel;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [DAT_W-1:0]   rsp_dat;
  logic               rsp_err;
  logic               rsp_timeout;

  logic [ADR_W-1:0]   WBs_ADR;
  logic               WBs_CYC;
  logic               WBs_STB;
  logic               WBs_WE;
  logic               WBs_RD;
  logic [DAT_W/8-1:0] WBs_BYTE_STB;
  logic [DAT_W-1:0]   WBs_WR_DAT;
  logic [DAT_W-1:0]   WBs_RD_DAT;
  logic               WBs_ACK;
  logic               WBs_ERR;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
    input  WBs_RD_DAT, WBs_ACK, WBs_ERR,
    output cmd_ready, rsp_valid, rsp_dat, rsp_err, rsp_timeout,
    output WBs_ADR, WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_BYTE_STB, WBs_WR_DAT
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
    output WBs_RD_DAT, WBs_ACK, WBs_ERR,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_err, rsp_timeout,
    input  WBs_ADR, WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_BYTE_STB, WBs_WR_DAT
  );
endinterface

// File: rtl/wb_cmd_watchdog.sv
// Bus-cycle watchdog: counter cleared on cycle start, counts while enabled,
// expire flags the last permitted cycle. TIMEOUT_CYCLES = 0 disables it.
module wb_cmd_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      assign expire = en && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/wb_cmd_initiator.sv
// Single-outstanding Wishbone classic initiator: one command in, one bus
// cycle, one response out. All outputs registered.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// BUS   | CYC/STB high, waiting for ACK/ERR or watchdog expiry
// RESP  | rsp_valid high, waiting for rsp_ready
module wb_cmd_initiator
  import wb_cmd_pkg::*;
#(
  parameter int ADR_W          = 17,
  parameter int DAT_W          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                WB_CLK,
  input  logic                WB_RST_n,
  wb_cmd_initiator_if.master  bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_BUS  = BUS;
  localparam logic [1:0] S_RESP = RESP;
  localparam int         CNT_W  = wd_cnt_width(TIMEOUT_CYCLES);

  generate
    if (ADR_W < 1 || DAT_W < 8 || (DAT_W % 8) != 0) begin : g_bad_param
      $error("wb_cmd_initiator: DAT_W must be a multiple of 8 and ADR_W >= 1");
    end
  endgenerate

  logic [1:0]  state;
  logic        accept;
  logic        in_bus;
  logic        wd_expire;
  logic        bus_done;
  rsp_status_e bus_status;

  assign accept = (state == S_IDLE) && bus.cmd_valid;
  assign in_bus = (state == S_BUS);

  wb_cmd_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clk_sys (WB_CLK),
    .rst_b   (WB_RST_n),
    .clr     (accept),
    .en      (in_bus),
    .expire  (wd_expire)
  );

  // ERR beats ACK, and any bus response beats the watchdog.
  always_comb begin
    bus_done   = 1'b1;
    bus_status = RSP_OK;
    if (bus.WBs_ERR) begin
      bus_status = RSP_ERR;
    end else if (bus.WBs_ACK) begin
      bus_status = RSP_OK;
    end else if (wd_expire) begin
      bus_status = RSP_TIMEOUT;
    end else begin
      bus_done = 1'b0;
    end
  end

  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) begin
      state            <= S_IDLE;
      bus.cmd_ready    <= 1'b1;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_dat      <= '0;
      bus.rsp_err      <= 1'b0;
      bus.rsp_timeout  <= 1'b0;
      bus.WBs_ADR      <= '0;
      bus.WBs_CYC      <= 1'b0;
      bus.WBs_STB      <= 1'b0;
      bus.WBs_WE       <= 1'b0;
      bus.WBs_RD       <= 1'b0;
      bus.WBs_BYTE_STB <= '0;
      bus.WBs_WR_DAT   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            state            <= S_BUS;
            bus.cmd_ready    <= 1'b0;
            bus.WBs_ADR      <= bus.cmd_adr;
            bus.WBs_WR_DAT   <= bus.cmd_dat;
            bus.WBs_BYTE_STB <= bus.cmd_sel;
            bus.WBs_WE       <= bus.cmd_we;
            bus.WBs_RD       <= ~bus.cmd_we;
            bus.WBs_CYC      <= 1'b1;
            bus.WBs_STB      <= 1'b1;
          end
        end
        S_BUS: begin
          if (bus_done) begin
            state           <= S_RESP;
            bus.WBs_CYC     <= 1'b0;
            bus.WBs_STB     <= 1'b0;
            bus.WBs_WE      <= 1'b0;
            bus.WBs_RD      <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_err     <= (bus_status != RSP_OK);
            bus.rsp_timeout <= (bus_status == RSP_TIMEOUT);
            bus.rsp_dat     <= (bus_status == RSP_OK && !bus.WBs_WE) ?
                               bus.WBs_RD_DAT : {DAT_W{1'b0}};
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state         <= S_IDLE;
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Self-checking bench for wb_cmd_initiator: transaction-level expectations
// derived from the command/response timeline, compared every cycle.
module tb_wb_cmd_initiator;

  localparam int ADR_W = 17;
  localparam int DAT_W = 32;
  localparam int TO    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  wb_cmd_initiator_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) bus ();

  wb_cmd_initiator #(
    .ADR_W          (ADR_W),
    .DAT_W          (DAT_W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .WB_CLK   (clk),
    .WB_RST_n (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  logic checking = 1'b0;

  // expected outputs after the coming rising edge
  logic             e_ready, e_cyc, e_we, e_rd, e_rsp_valid, e_rsp_err, e_rsp_to;
  logic [ADR_W-1:0] e_adr;
  logic [DAT_W-1:0] e_wdat, e_rdat;
  logic [3:0]       e_sel;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_reset();
    e_ready = 1'b1; e_cyc = 1'b0; e_we = 1'b0; e_rd = 1'b0;
    e_rsp_valid = 1'b0; e_rsp_err = 1'b0; e_rsp_to = 1'b0;
    e_adr = '0; e_wdat = '0; e_rdat = '0; e_sel = '0;
  endtask

  always @(posedge clk) begin
    #1;
    if (bus.WBs_CYC) cyc_cnt++;
    if (checking) begin
      chk("cmd_ready", bus.cmd_ready, e_ready);
      chk("cyc", bus.WBs_CYC, e_cyc);
      chk("stb", bus.WBs_STB, e_cyc);
      chk("we", bus.WBs_WE, e_we);
      chk("rd", bus.WBs_RD, e_rd);
      chk("rsp_valid", bus.rsp_valid, e_rsp_valid);
      chk("adr", bus.WBs_ADR, e_adr);
      chk("wr_dat", bus.WBs_WR_DAT, e_wdat);
      chk("byte_stb", bus.WBs_BYTE_STB, e_sel);
      if (e_rsp_valid) begin
        chk("rsp_dat", bus.rsp_dat, e_rdat);
        chk("rsp_err", bus.rsp_err, e_rsp_err);
        chk("rsp_timeout", bus.rsp_timeout, e_rsp_to);
      end
    end
  end

  // kind: 0 = ACK, 1 = ERR, 2 = ACK and ERR together. resp_cyc 0 = silent slave.
  task automatic run_cmd(
    input  logic             we,
    input  logic [ADR_W-1:0] adr,
    input  logic [DAT_W-1:0] dat,
    input  logic [3:0]       sel,
    input  int               resp_cyc,
    input  int               kind,
    input  logic [DAT_W-1:0] rdat,
    input  int               ready_delay,
    input  logic             pester,
    output int               n_cyc,
    output logic [DAT_W-1:0] o_dat,
    output logic             o_err,
    output logic             o_to
  );
    int len, outcome, c0;
    if (resp_cyc >= 1 && resp_cyc <= TO) begin
      len = resp_cyc;
      outcome = (kind == 0) ? 0 : 1;
    end else begin
      len = TO;
      outcome = 2;
    end
    @(negedge clk);
    c0 = cyc_cnt;
    bus.cmd_valid = 1'b1; bus.cmd_we = we; bus.cmd_adr = adr;
    bus.cmd_dat = dat; bus.cmd_sel = sel;
    bus.WBs_ACK = 1'b0; bus.WBs_ERR = 1'b0; bus.rsp_ready = 1'b0;
    e_ready = 1'b0; e_cyc = 1'b1; e_we = we; e_rd = !we;
    e_adr = adr; e_wdat = dat; e_sel = sel; e_rsp_valid = 1'b0;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      if (pester) begin
        bus.cmd_we = 1'($urandom); bus.cmd_adr = ADR_W'($urandom);
        bus.cmd_dat = $urandom; bus.cmd_sel = 4'($urandom);
      end else begin
        bus.cmd_valid = 1'b0;
      end
      bus.WBs_ACK    = (i == resp_cyc) && (kind != 1);
      bus.WBs_ERR    = (i == resp_cyc) && (kind != 0);
      bus.WBs_RD_DAT = (i == resp_cyc) ? rdat : $urandom;
      if (i == len) begin
        e_cyc = 1'b0; e_we = 1'b0; e_rd = 1'b0; e_rsp_valid = 1'b1;
        e_rsp_err = (outcome != 0);
        e_rsp_to  = (outcome == 2);
        e_rdat    = (outcome == 0 && !we) ? rdat : '0;
      end
    end
    o_dat = '0; o_err = 1'b0; o_to = 1'b0;
    for (int j = 0; j <= ready_delay; j++) begin
      @(negedge clk);
      if (j == 0) begin
        o_dat = bus.rsp_dat; o_err = bus.rsp_err; o_to = bus.rsp_timeout;
      end
      bus.WBs_ACK    = pester ? 1'($urandom) : 1'b0;
      bus.WBs_ERR    = pester ? 1'($urandom) : 1'b0;
      bus.WBs_RD_DAT = $urandom;
      bus.rsp_ready  = (j == ready_delay);
      if (j == ready_delay) begin
        e_rsp_valid = 1'b0; e_ready = 1'b1;
      end
    end
    n_cyc = cyc_cnt - c0;
  endtask

  task automatic idle(input int n, input logic stray);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'($urandom);
      bus.WBs_ACK   = stray ? 1'($urandom) : 1'b0;
      bus.WBs_ERR   = stray ? 1'($urandom) : 1'b0;
    end
  endtask

  int               n_cyc;
  logic [DAT_W-1:0] o_dat;
  logic             o_err, o_to;

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_adr = '0;
    bus.cmd_dat = '0; bus.cmd_sel = '0; bus.rsp_ready = 1'b0;
    bus.WBs_RD_DAT = '0; bus.WBs_ACK = 1'b0; bus.WBs_ERR = 1'b0;
    expect_reset();
    checking = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_cmd_ready", bus.cmd_ready, 1'b1);
    chk("reset_cyc", bus.WBs_CYC, 1'b0);
    rst_n = 1'b1;
    idle(2, 1'b1);

    // write, ACK on 3rd bus cycle
    run_cmd(1'b1, 17'h00010, 32'hA5A5_0001, 4'hF, 3, 0, 32'hDEAD_BEEF, 0, 1'b0,
            n_cyc, o_dat, o_err, o_to);
    chk("wr_cyc_len", n_cyc, 3);
    chk("wr_rsp_dat", o_dat, 32'h0);
    chk("wr_rsp_err", o_err, 1'b0);

    // read, ACK on 1st bus cycle
    run_cmd(1'b0, 17'h00014, 32'h0, 4'hF, 1, 0, 32'h1234_5678, 1, 1'b0,
            n_cyc, o_dat, o_err, o_to);
    chk("rd_cyc_len", n_cyc, 1);
    chk("rd_rsp_dat", o_dat, 32'h1234_5678);

    // silent slave
    run_cmd(1'b0, 17'h00020, 32'h0, 4'hF, 0, 0, 32'h1111_2222, 0, 1'b0,
            n_cyc, o_dat, o_err, o_to);
    chk("to_cyc_len", n_cyc, 8);
    chk("to_rsp_err", o_err, 1'b1);
    chk("to_rsp_timeout", o_to, 1'b1);
    chk("to_rsp_dat", o_dat, 32'h0);

    run_cmd(1'b0, 17'h00024, 32'h0, 4'h3, 2, 0, 32'hCAFE_F00D, 0, 1'b0,
            n_cyc, o_dat, o_err, o_to);
    chk("after_to_dat", o_dat, 32'hCAFE_F00D);
    chk("after_to_err", o_err, 1'b0);

    // ACK and ERR together
    run_cmd(1'b0, 17'h00028, 32'h0, 4'hF, 2, 2, 32'h5555_AAAA, 0, 1'b0,
            n_cyc, o_dat, o_err, o_to);
    chk("ackerr_err", o_err, 1'b1);
    chk("ackerr_timeout", o_to, 1'b0);
    chk("ackerr_dat", o_dat, 32'h0);

    // ACK on the cycle the watchdog would fire
    run_cmd(1'b0, 17'h0002C, 32'h0, 4'hF, 8, 0, 32'h0BAD_CAFE, 0, 1'b0,
            n_cyc, o_dat, o_err, o_to);
    chk("ack8_cyc_len", n_cyc, 8);
    chk("ack8_err", o_err, 1'b0);
    chk("ack8_timeout", o_to, 1'b0);
    chk("ack8_dat", o_dat, 32'h0BAD_CAFE);

    run_cmd(1'b1, 17'h00030, 32'h7777_8888, 4'h1, 8, 1, 32'h0, 0, 1'b0,
            n_cyc, o_dat, o_err, o_to);
    chk("err8_err", o_err, 1'b1);
    chk("err8_timeout", o_to, 1'b0);

    // backpressure with cmd_valid held and stray responses
    run_cmd(1'b0, 17'h00034, 32'h0, 4'hF, 4, 0, 32'h89AB_CDEF, 10, 1'b1,
            n_cyc, o_dat, o_err, o_to);
    chk("bp_dat", o_dat, 32'h89AB_CDEF);
    idle(2, 1'b1);

    // reset in the middle of a bus cycle
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_adr = 17'h00040;
    bus.cmd_dat = '0; bus.cmd_sel = 4'hF;
    bus.WBs_ACK = 1'b0; bus.WBs_ERR = 1'b0; bus.rsp_ready = 1'b1;
    e_ready = 1'b0; e_cyc = 1'b1; e_we = 1'b0; e_rd = 1'b1;
    e_adr = 17'h00040; e_wdat = '0; e_sel = 4'hF; e_rsp_valid = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cyc", bus.WBs_CYC, 1'b0);
    chk("async_rst_stb", bus.WBs_STB, 1'b0);
    chk("async_rst_rsp_valid", bus.rsp_valid, 1'b0);
    expect_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1, 1'b0);
    chk("post_rst_ready", bus.cmd_ready, 1'b1);
    run_cmd(1'b0, 17'h00044, 32'h0, 4'hF, 3, 0, 32'h2468_ACE0, 0, 1'b0,
            n_cyc, o_dat, o_err, o_to);
    chk("post_rst_dat", o_dat, 32'h2468_ACE0);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      run_cmd(1'($urandom), ADR_W'($urandom), $urandom, 4'($urandom),
              int'($urandom_range(0, 10)), int'($urandom_range(0, 2)), $urandom,
              int'($urandom_range(0, 3)), 1'($urandom), n_cyc, o_dat, o_err, o_to);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)), 1'b1);
    end
    idle(2, 1'b0);

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
